// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequences MEM-stage loads/stores into the L1 D-cache
// request handshake, stalls until ack, returns extended big-endian load data.
//
// Ports:
//   clk, rst              clock, async active-high reset
//   mem_valid_i/op/addr/wdata  MEM-stage operation
//   flush_i               pipeline flush (suppresses a pending load result)
//   stall_req_o           hold the pipeline
//   load_data_o/valid_o   extended load result, one-cycle valid pulse
//   adel_o/ades_o         misaligned load/store address errors
//   sysce_o/syswe_o/sel_o/addr_o/data_to_store_o  cache request
//   data_to_load_i, cache_ack_i  cache response
module mem_access_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid_i,
    input  logic [3:0]  mem_op_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    input  logic        flush_i,
    output logic        stall_req_o,
    output logic [31:0] load_data_o,
    output logic        load_valid_o,
    output logic        adel_o,
    output logic        ades_o,
    output logic        sysce_o,
    output logic        syswe_o,
    output logic [3:0]  sel_o,
    output logic [31:0] addr_o,
    output logic [31:0] data_to_store_o,
    input  logic [31:0] data_to_load_i,
    input  logic        cache_ack_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LBU = 4'd2;
    localparam logic [3:0] OP_LH  = 4'd3;
    localparam logic [3:0] OP_LHU = 4'd4;
    localparam logic [3:0] OP_LW  = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;

    function automatic logic is_load(input logic [3:0] op);
        return (op >= OP_LB) && (op <= OP_LW);
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return (op >= OP_SB) && (op <= OP_SW);
    endfunction

    state_t      state_q, state_d;
    logic        sysce_q, sysce_d;
    logic        syswe_q, syswe_d;
    logic [3:0]  sel_q, sel_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  op_q, op_d;
    logic [1:0]  off_q, off_d;
    logic        kill_q, kill_d;
    logic [31:0] ldata_q, ldata_d;

    // Decode of the incoming operation
    logic        in_load, in_store, in_byte, in_half, in_word;
    logic        aligned, start;
    logic [3:0]  lane_sel;
    logic [31:0] st_data;

    always_comb begin
        in_load  = is_load(mem_op_i);
        in_store = is_store(mem_op_i);
        in_byte  = (mem_op_i == OP_LB) || (mem_op_i == OP_LBU)
                || (mem_op_i == OP_SB);
        in_half  = (mem_op_i == OP_LH) || (mem_op_i == OP_LHU)
                || (mem_op_i == OP_SH);
        in_word  = (mem_op_i == OP_LW) || (mem_op_i == OP_SW);
        aligned  = in_byte
                || (in_half && !mem_addr_i[0])
                || (in_word && (mem_addr_i[1:0] == 2'b00));
        start    = (state_q == IDLE) && mem_valid_i
                && (in_load || in_store) && aligned && !flush_i;
    end

    // Byte lanes and replicated store data (big-endian: offset 0 is [31:24])
    always_comb begin
        lane_sel = 4'b0000;
        st_data  = mem_wdata_i;
        if (in_byte) begin
            lane_sel = 4'b1000 >> mem_addr_i[1:0];
            st_data  = {4{mem_wdata_i[7:0]}};
        end else if (in_half) begin
            lane_sel = mem_addr_i[1] ? 4'b0011 : 4'b1100;
            st_data  = {2{mem_wdata_i[15:0]}};
        end else if (in_word) begin
            lane_sel = 4'b1111;
            st_data  = mem_wdata_i;
        end
    end

    // Lane extraction of the returning cache word
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] rd_ext;

    always_comb begin
        unique case (off_q)
            2'd0:    rd_byte = data_to_load_i[31:24];
            2'd1:    rd_byte = data_to_load_i[23:16];
            2'd2:    rd_byte = data_to_load_i[15:8];
            default: rd_byte = data_to_load_i[7:0];
        endcase
        rd_half = off_q[1] ? data_to_load_i[15:0] : data_to_load_i[31:16];
        unique case (op_q)
            OP_LB:   rd_ext = {{24{rd_byte[7]}}, rd_byte};
            OP_LBU:  rd_ext = {24'h0, rd_byte};
            OP_LH:   rd_ext = {{16{rd_half[15]}}, rd_half};
            OP_LHU:  rd_ext = {16'h0, rd_half};
            default: rd_ext = data_to_load_i;
        endcase
    end

    always_comb begin
        state_d = state_q;
        sysce_d = sysce_q;
        syswe_d = syswe_q;
        sel_d   = sel_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        op_d    = op_q;
        off_d   = off_q;
        kill_d  = kill_q;
        ldata_d = ldata_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = REQ;
                    sysce_d = 1'b1;
                    syswe_d = in_store;
                    sel_d   = lane_sel;
                    addr_d  = {mem_addr_i[31:2], 2'b00};
                    wdata_d = st_data;
                    op_d    = mem_op_i;
                    off_d   = mem_addr_i[1:0];
                    kill_d  = 1'b0;
                end
            end
            REQ: begin
                // A flush never aborts the bus transaction; it only
                // marks the result as dead, including on the ack cycle.
                if (flush_i) begin
                    kill_d = 1'b1;
                end
                if (cache_ack_i) begin
                    state_d = DONE;
                    sysce_d = 1'b0;
                    syswe_d = 1'b0;
                    sel_d   = 4'b0000;
                    if (is_load(op_q) && !kill_q && !flush_i) begin
                        ldata_d = rd_ext;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                kill_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sysce_q <= 1'b0;
            syswe_q <= 1'b0;
            sel_q   <= 4'b0000;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            op_q    <= 4'h0;
            off_q   <= 2'b00;
            kill_q  <= 1'b0;
            ldata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            sysce_q <= sysce_d;
            syswe_q <= syswe_d;
            sel_q   <= sel_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            op_q    <= op_d;
            off_q   <= off_d;
            kill_q  <= kill_d;
            ldata_q <= ldata_d;
        end
    end

    // Stall drops in DONE so the pipeline advances exactly once.
    assign stall_req_o     = start || (state_q == REQ);
    assign adel_o          = (state_q == IDLE) && mem_valid_i
                          && in_load && !aligned;
    assign ades_o          = (state_q == IDLE) && mem_valid_i
                          && in_store && !aligned;
    assign load_valid_o    = (state_q == DONE) && is_load(op_q) && !kill_q;
    assign load_data_o     = ldata_q;
    assign sysce_o         = sysce_q;
    assign syswe_o         = syswe_q;
    assign sel_o           = sel_q;
    assign addr_o          = addr_q;
    assign data_to_store_o = wdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed and random load/store transactions checked
// against a transaction-level model of lanes, alignment and extension.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid_i;
    logic [3:0]  mem_op_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_wdata_i;
    logic        flush_i;
    logic        stall_req_o;
    logic [31:0] load_data_o;
    logic        load_valid_o;
    logic        adel_o;
    logic        ades_o;
    logic        sysce_o;
    logic        syswe_o;
    logic [3:0]  sel_o;
    logic [31:0] addr_o;
    logic [31:0] data_to_store_o;
    logic [31:0] data_to_load_i;
    logic        cache_ack_i;

    int nvec = 0;
    int nerr = 0;
    logic [31:0] last_ld = 32'h0;

    mem_access_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .mem_valid_i     (mem_valid_i),
        .mem_op_i        (mem_op_i),
        .mem_addr_i      (mem_addr_i),
        .mem_wdata_i     (mem_wdata_i),
        .flush_i         (flush_i),
        .stall_req_o     (stall_req_o),
        .load_data_o     (load_data_o),
        .load_valid_o    (load_valid_o),
        .adel_o          (adel_o),
        .ades_o          (ades_o),
        .sysce_o         (sysce_o),
        .syswe_o         (syswe_o),
        .sel_o           (sel_o),
        .addr_o          (addr_o),
        .data_to_store_o (data_to_store_o),
        .data_to_load_i  (data_to_load_i),
        .cache_ack_i     (cache_ack_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Access size in bytes, 0 for non-memory codes
    function automatic int op_size(input logic [3:0] op);
        case (op)
            4'd1, 4'd2, 4'd6: return 1;
            4'd3, 4'd4, 4'd7: return 2;
            4'd5, 4'd8:       return 4;
            default:          return 0;
        endcase
    endfunction

    // Reference result of a load given the full cache word
    function automatic logic [31:0] ref_load(input logic [3:0] op,
                                             input int off,
                                             input logic [31:0] w);
        logic [31:0] b, h;
        b = (w >> (8 * (3 - off))) & 32'hFF;
        h = (w >> (16 * (1 - off / 2))) & 32'hFFFF;
        case (op)
            4'd1:    return (b >= 128) ? (b | 32'hFFFF_FF00) : b;
            4'd2:    return b;
            4'd3:    return (h >= 32768) ? (h | 32'hFFFF_0000) : h;
            4'd4:    return h;
            default: return w;
        endcase
    endfunction

    // Called one step after a rising edge with the DUT idle.
    // dly = cycle (>=1) of cache ack; fc = REQ cycle carrying a flush (0 none).
    task automatic do_op(input logic [3:0] op, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] rd,
                         input int dly, input int fc);
        int sz, off;
        bit ld, st, al, go, killed;
        logic [3:0]  xsel;
        logic [31:0] xdat, xld;
        sz  = op_size(op);
        off = int'(addr[1:0]);
        ld  = (op >= 4'd1) && (op <= 4'd5);
        st  = (op >= 4'd6) && (op <= 4'd8);
        al  = (sz != 0) && ((off % sz) == 0);
        go  = (ld || st) && al;
        killed = 1'b0;
        if (sz == 1) begin
            xsel = 4'b0001 << (3 - off);
            xdat = {4{wd[7:0]}};
        end else if (sz == 2) begin
            xsel = (off == 0) ? 4'b1100 : 4'b0011;
            xdat = {2{wd[15:0]}};
        end else begin
            xsel = 4'b1111;
            xdat = wd;
        end
        mem_valid_i = 1'b1;
        mem_op_i    = op;
        mem_addr_i  = addr;
        mem_wdata_i = wd;
        flush_i     = 1'b0;
        @(negedge clk);
        chk("stall_start", stall_req_o, go);
        chk("adel", adel_o, ld && !al);
        chk("ades", ades_o, st && !al);
        if (!go) begin
            @(posedge clk); #1;
            mem_valid_i = 1'b0;
            chk("no_req", sysce_o, 0);
            return;
        end
        for (int c = 1; c <= dly; c++) begin
            @(posedge clk); #1;
            flush_i = (c == fc);
            if (c == fc) killed = 1'b1;
            cache_ack_i = (c == dly);
            data_to_load_i = (c == dly) ? rd : $urandom;
            chk("sysce", sysce_o, 1);
            chk("syswe", syswe_o, st);
            chk("sel", sel_o, xsel);
            chk("addr", addr_o, {addr[31:2], 2'b00});
            if (st) chk("st_data", data_to_store_o, xdat);
            chk("stall_req", stall_req_o, 1);
        end
        @(posedge clk); #1;
        cache_ack_i = 1'b0;
        flush_i     = 1'b0;
        mem_valid_i = 1'b0;
        chk("done_sysce", sysce_o, 0);
        chk("done_sel", sel_o, 0);
        chk("done_stall", stall_req_o, 0);
        chk("load_valid", load_valid_o, ld && !killed);
        if (ld && !killed) begin
            xld = ref_load(op, off, rd);
            chk("load_data", load_data_o, xld);
            last_ld = xld;
        end
        @(posedge clk); #1;
        chk("lv_pulse", load_valid_o, 0);
        chk("ld_hold", load_data_o, last_ld);
    endtask

    initial begin
        rst = 1'b1;
        mem_valid_i = 1'b0;
        mem_op_i = 4'h0;
        mem_addr_i = 32'h0;
        mem_wdata_i = 32'h0;
        flush_i = 1'b0;
        data_to_load_i = 32'h0;
        cache_ack_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_sysce", sysce_o, 0);
        chk("rst_stall", stall_req_o, 0);
        chk("rst_lv", load_valid_o, 0);
        chk("rst_ld", load_data_o, 0);
        chk("rst_addr", addr_o, 0);
        chk("rst_sel", sel_o, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        do_op(4'd8, 32'h0000_0008, 32'h6868_6868, 32'h0, 4, 0);
        do_op(4'd6, 32'h0000_0C11, 32'h0000_00AB, 32'h0, 1, 0);
        do_op(4'd1, 32'h0000_0001, 32'h0, 32'h1280_3456, 1, 0);
        do_op(4'd2, 32'h0000_0001, 32'h0, 32'h1280_3456, 2, 0);
        do_op(4'd3, 32'h0000_0002, 32'h0, 32'h1280_3456, 1, 0);
        do_op(4'd5, 32'h0000_0006, 32'h0, 32'h0, 1, 0);
        do_op(4'd7, 32'h0000_0003, 32'h1234, 32'h0, 1, 0);
        do_op(4'd5, 32'h0000_0010, 32'h0, 32'hCAFE_BABE, 4, 1);
        do_op(4'd3, 32'h0000_0000, 32'h0, 32'h8001_0000, 2, 2);

        // Flush in IDLE blocks the start
        mem_valid_i = 1'b1;
        mem_op_i = 4'd5;
        mem_addr_i = 32'h20;
        flush_i = 1'b1;
        @(negedge clk);
        chk("flush_idle_stall", stall_req_o, 0);
        @(posedge clk); #1;
        chk("flush_idle_sysce", sysce_o, 0);
        mem_valid_i = 1'b0;
        flush_i = 1'b0;
        @(posedge clk); #1;

        // Reset in REQ: drops immediately, later ack ignored
        mem_valid_i = 1'b1;
        mem_op_i = 4'd5;
        mem_addr_i = 32'h40;
        @(posedge clk); #1;
        chk("pre_rst_sysce", sysce_o, 1);
        mem_valid_i = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_req_sysce", sysce_o, 0);
        chk("rst_req_stall", stall_req_o, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        last_ld = 32'h0;
        cache_ack_i = 1'b1;
        data_to_load_i = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        cache_ack_i = 1'b0;
        chk("rst_ack_lv", load_valid_o, 0);
        chk("rst_ack_sysce", sysce_o, 0);
        @(posedge clk); #1;
        chk("rst_ack_lv2", load_valid_o, 0);
        chk("rst_ack_ld", load_data_o, 0);

        for (int i = 0; i < 300; i++) begin
            logic [3:0]  op;
            logic [31:0] a;
            int d, f;
            op = 4'($urandom_range(0, 10));
            a  = {$urandom} & 32'h0000_FFFF;
            d  = $urandom_range(1, 5);
            f  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, d) : 0;
            do_op(op, a, $urandom, $urandom, d, f);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
